// File: rtl/arcade_input_mapper_pkg.sv
// Shared types for the arcade input mapper: source kinds, map entry layout, scanner states.
package arcade_input_pkg;

    typedef enum logic [1:0] {
        SRC_CONST = 2'd0,
        SRC_JOY   = 2'd1,
        SRC_DIP   = 2'd2,
        SRC_COIN  = 2'd3
    } src_kind_e;

    localparam logic [7:0] DIP_IOCTL_INDEX = 8'd254;
    localparam int         KIND_W          = 2;
    localparam int         SEL_W           = 6;
    localparam int         JOY_COIN_BIT    = 4;

    typedef struct packed {
        src_kind_e          kind;
        logic [SEL_W-1:0]   sel;
    } map_entry_t;

    typedef enum logic {
        ST_SCAN   = 1'b0,
        ST_COMMIT = 1'b1
    } scan_state_e;

endpackage

// File: rtl/arcade_input_mapper_coin_stretch.sv
// Coin pulse stretcher: a rising edge on coin_raw (re)loads a down-counter; coin_any while nonzero.
module coin_stretch #(
    parameter logic [15:0] COIN_STRETCH = 16'd50000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic coin_raw,
    output logic coin_any
);

    logic        coin_prev;
    logic [15:0] cnt_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            coin_prev <= 1'b0;
            cnt_q     <= '0;
        end else begin
            coin_prev <= coin_raw;
            if (coin_raw && !coin_prev)
                cnt_q <= COIN_STRETCH;
            else if (cnt_q != 16'd0)
                cnt_q <= cnt_q - 16'd1;
        end
    end

    assign coin_any = (cnt_q != 16'd0);

endmodule

// File: rtl/arcade_input_mapper.sv
// Table-driven input/DIP byte assembly. Optional coin stretching under ARCADE_INPUT_COIN_STRETCH_EN.
// state  | meaning
// SCAN   | evaluate bit (p,b) of the map, shift into staging
// COMMIT | publish staging to in_port[p], advance to next port
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int          NUM_PLAYERS   = 4,
    parameter int          NUM_PORTS     = 3,
    parameter int          NUM_DIP_BYTES = 8,
    parameter logic [7:0]  MAP_INDEX     = 8'd2,
    parameter logic [15:0] COIN_STRETCH  = 16'd50000
) (
    input  logic                           clk_sys,
    input  logic                           reset_n,
    input  logic                           ioctl_wr,
    input  logic [7:0]                     ioctl_index,
    input  logic [24:0]                    ioctl_addr,
    input  logic [7:0]                     ioctl_dout,
    input  logic [NUM_PLAYERS-1:0][15:0]   joystick,
    output logic [NUM_DIP_BYTES-1:0][7:0]  dip,
    output logic [NUM_PORTS-1:0][7:0]      in_port,
    output logic                           port_valid,
    output logic                           scan_done
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int MW = $clog2(NUM_PORTS * 8);
    localparam int DW = (NUM_DIP_BYTES > 1) ? $clog2(NUM_DIP_BYTES) : 1;
    localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

    map_entry_t  map_q [NUM_PORTS*8];
    logic [7:0]  pol_q [NUM_PORTS];

    scan_state_e state_q, state_d;
    logic [PW-1:0] ptr_p_q, ptr_p_d;
    logic [2:0]    ptr_b_q, ptr_b_d;
    logic [7:0]    stage_q, stage_d;
    logic          commit, wrap;

    logic [63:0]   joy_pad, dip_pad;
    logic          coin_raw, coin_any;
    map_entry_t    entry;
    logic          src_bit, scan_bit;

    logic map_wr, pol_wr, dip_wr;
    assign map_wr = ioctl_wr && (ioctl_index == MAP_INDEX) && (ioctl_addr < 25'(NUM_PORTS * 8));
    assign pol_wr = ioctl_wr && (ioctl_index == MAP_INDEX) && (ioctl_addr >= 25'(NUM_PORTS * 8))
                    && (ioctl_addr < 25'(NUM_PORTS * 9));
    assign dip_wr = ioctl_wr && (ioctl_index == DIP_IOCTL_INDEX) && (ioctl_addr < 25'(NUM_DIP_BYTES));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PORTS * 8; i++) map_q[i] <= '0;
            for (int i = 0; i < NUM_PORTS; i++)     pol_q[i] <= 8'hFF;
            dip <= '0;
        end else begin
            if (map_wr) map_q[ioctl_addr[MW-1:0]] <= ioctl_dout;
            if (pol_wr) pol_q[PW'(ioctl_addr - 25'(NUM_PORTS * 8))] <= ioctl_dout;
            if (dip_wr) dip[ioctl_addr[DW-1:0]] <= ioctl_dout;
        end
    end

    // Zero padding makes out-of-range players and DIP indices read as 0.
    always_comb begin
        joy_pad = '0;
        joy_pad[NUM_PLAYERS*16-1:0] = joystick;
        dip_pad = '0;
        dip_pad[NUM_DIP_BYTES*8-1:0] = dip;
        coin_raw = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) coin_raw = coin_raw | joystick[i][JOY_COIN_BIT];
    end

`ifdef ARCADE_INPUT_COIN_STRETCH_EN
    coin_stretch #(.COIN_STRETCH(COIN_STRETCH)) u_coin_stretch (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .coin_raw (coin_raw),
        .coin_any (coin_any)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^COIN_STRETCH;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) coin_any <= 1'b0;
        else          coin_any <= coin_raw;
    end
`endif

    always_comb begin
        entry   = map_q[MW'({ptr_p_q, ptr_b_q})];
        src_bit = 1'b0;
        case (entry.kind)
            SRC_CONST: src_bit = entry.sel[0];
            SRC_JOY:   src_bit = joy_pad[entry.sel];
            SRC_DIP:   src_bit = dip_pad[entry.sel];
            SRC_COIN:  src_bit = coin_any;
            default:   src_bit = 1'b0;
        endcase
        scan_bit = src_bit ^ pol_q[ptr_p_q][ptr_b_q];
    end

    always_comb begin
        state_d = state_q;
        ptr_p_d = ptr_p_q;
        ptr_b_d = ptr_b_q;
        stage_d = stage_q;
        commit  = 1'b0;
        wrap    = 1'b0;
        case (state_q)
            ST_SCAN: begin
                stage_d = {scan_bit, stage_q[7:1]};
                ptr_b_d = ptr_b_q + 3'd1;
                if (ptr_b_q == 3'd7) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                ptr_b_d = 3'd0;
                state_d = ST_SCAN;
                if (ptr_p_q == LAST_PORT) begin
                    ptr_p_d = '0;
                    wrap    = 1'b1;
                end else begin
                    ptr_p_d = ptr_p_q + PW'(1);
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_SCAN;
            ptr_p_q    <= '0;
            ptr_b_q    <= '0;
            stage_q    <= '0;
            in_port    <= {NUM_PORTS{8'hFF}};
            port_valid <= 1'b0;
            scan_done  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_p_q    <= ptr_p_d;
            ptr_b_q    <= ptr_b_d;
            stage_q    <= stage_d;
            if (commit) in_port[ptr_p_q] <= stage_q;
            scan_done  <= wrap;
            port_valid <= port_valid | wrap;
        end
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper with a scoreboard of expected port bytes.
module tb_arcade_input_mapper;

    localparam int         NP   = 2;
    localparam int         NPRT = 3;
    localparam int         ND   = 4;
    localparam logic [7:0] MAPI = 8'd2;

    logic                  clk_sys = 1'b0;
    logic                  reset_n;
    logic                  ioctl_wr;
    logic [7:0]            ioctl_index;
    logic [24:0]           ioctl_addr;
    logic [7:0]            ioctl_dout;
    logic [NP-1:0][15:0]   joystick;
    logic [ND-1:0][7:0]    dip;
    logic [NPRT-1:0][7:0]  in_port;
    logic                  port_valid;
    logic                  scan_done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         port;
        logic [7:0] exp;
        string      tag;
    } sb_t;
    sb_t sb_q[$];

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper #(
        .NUM_PLAYERS   (NP),
        .NUM_PORTS     (NPRT),
        .NUM_DIP_BYTES (ND),
        .MAP_INDEX     (MAPI),
        .COIN_STRETCH  (16'd100)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ioctl_wr    (ioctl_wr),
        .ioctl_index (ioctl_index),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .joystick    (joystick),
        .dip         (dip),
        .in_port     (in_port),
        .port_valid  (port_valid),
        .scan_done   (scan_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ioctl_write(input logic [7:0] idx, input int addr, input logic [7:0] data);
        ioctl_wr    = 1'b1;
        ioctl_index = idx;
        ioctl_addr  = 25'(addr);
        ioctl_dout  = data;
        @(negedge clk_sys);
        ioctl_wr    = 1'b0;
    endtask

    task automatic wait_scan(output int n);
        n = 0;
        do begin
            @(negedge clk_sys);
            n++;
        end while (!scan_done && n < 60);
        if (!scan_done) chk("scan_timeout", 32'(scan_done), 32'd1);
    endtask

    task automatic expect_port(input int p, input logic [7:0] v, input string tag);
        sb_t it;
        it.port = p;
        it.exp  = v;
        it.tag  = tag;
        sb_q.push_back(it);
    endtask

    task automatic drain();
        int  n;
        sb_t it;
        wait_scan(n);
        wait_scan(n);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            chk(it.tag, 32'(in_port[it.port]), 32'(it.exp));
        end
    endtask

    initial begin
        int n;
        reset_n     = 1'b0;
        ioctl_wr    = 1'b0;
        ioctl_index = 8'd0;
        ioctl_addr  = '0;
        ioctl_dout  = 8'd0;
        joystick    = '0;
        repeat (3) @(negedge clk_sys);

        chk("rst_in_port", 32'(in_port), 32'hFFFFFF);
        chk("rst_port_valid", 32'(port_valid), 32'd0);
        chk("rst_scan_done", 32'(scan_done), 32'd0);
        chk("rst_dip", 32'(dip), 32'd0);

        // first scan after release completes on the 27th edge
        reset_n = 1'b1;
        wait_scan(n);
        chk("first_scan_cycles", 32'(n), 32'd27);
        chk("idle_in_port", 32'(in_port), 32'hFFFFFF);
        chk("port_valid_set", 32'(port_valid), 32'd1);
        @(negedge clk_sys);
        chk("scan_done_pulse", 32'(scan_done), 32'd0);
        wait_scan(n);
        chk("scan_period", 32'(n), 32'd26);

        // port0 bit7 <- player0 bit0, inverted
        ioctl_write(MAPI, 7, 8'h40);
        joystick[0][0] = 1'b1;
        n = 0;
        while (in_port[0] !== 8'h7F && n < 40) begin
            @(negedge clk_sys);
            n++;
        end
        chk("joy_latency_ok", 32'(n <= 28), 32'd1);
        expect_port(0, 8'h7F, "joy_pressed");
        drain();
        joystick[0][0] = 1'b0;
        expect_port(0, 8'hFF, "joy_released");
        drain();

        // DIP byte into port1, non-inverted
        ioctl_write(8'd254, 0, 8'hA5);
        for (int i = 0; i < 8; i++) ioctl_write(MAPI, 8 + i, 8'h80 | 8'(i));
        ioctl_write(MAPI, 25, 8'h00);
        ioctl_write(8'd254, 8, 8'h3C);
        ioctl_write(8'd254, 4, 8'h5A);
        chk("dip_capture", 32'(dip), 32'h000000A5);
        expect_port(1, 8'hA5, "dip_port1");
        drain();

        // mixed sources and out-of-range selects on port0
        ioctl_write(MAPI, 24, 8'h00);
        ioctl_write(MAPI, 0, 8'h70);
        ioctl_write(MAPI, 1, 8'hBF);
        ioctl_write(MAPI, 2, 8'h81);
        ioctl_write(MAPI, 3, 8'h82);
        ioctl_write(MAPI, 4, 8'h01);
        ioctl_write(MAPI, 5, 8'h00);
        ioctl_write(MAPI, 6, 8'h5F);
        joystick = '1;
        expect_port(0, 8'hD8, "mixed_joy_high");
        drain();
        joystick = '0;
        expect_port(0, 8'h18, "mixed_joy_low");
        expect_port(1, 8'hA5, "port1_stable");
        drain();

        // coin on port2 bit7, non-inverted
        repeat (120) @(negedge clk_sys);
        ioctl_write(MAPI, 23, 8'hC0);
        ioctl_write(MAPI, 26, 8'h00);
        expect_port(2, 8'h00, "coin_idle");
        drain();
`ifdef ARCADE_INPUT_COIN_STRETCH_EN
        joystick[1][4] = 1'b1;
        @(negedge clk_sys);
        joystick[1][4] = 1'b0;
        repeat (39) @(negedge clk_sys);
        chk("coin_stretch_early", 32'(in_port[2]), 32'h80);
        repeat (10) @(negedge clk_sys);
        joystick[1][4] = 1'b1;
        @(negedge clk_sys);
        joystick[1][4] = 1'b0;
        repeat (79) @(negedge clk_sys);
        chk("coin_retrigger", 32'(in_port[2]), 32'h80);
        repeat (60) @(negedge clk_sys);
        chk("coin_expired", 32'(in_port[2]), 32'h00);
`else
        joystick[1][4] = 1'b1;
        repeat (60) @(negedge clk_sys);
        chk("coin_held", 32'(in_port[2]), 32'h80);
        joystick[1][4] = 1'b0;
        expect_port(2, 8'h00, "coin_released");
        drain();
`endif

        // async reset while the pointer sits at (1,3)
        wait_scan(n);
        repeat (12) @(negedge clk_sys);
        reset_n = 1'b0;
        #1;
        chk("midscan_in_port", 32'(in_port), 32'hFFFFFF);
        chk("midscan_port_valid", 32'(port_valid), 32'd0);
        chk("midscan_dip", 32'(dip), 32'd0);
        chk("midscan_scan_done", 32'(scan_done), 32'd0);
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        wait_scan(n);
        chk("restart_scan_cycles", 32'(n), 32'd27);
        chk("restart_in_port", 32'(in_port), 32'hFFFFFF);
        chk("restart_port_valid", 32'(port_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
